// File: rtl/gvp_stream_packer.sv
// gvp_stream_packer: gvp vector snapshots -> tagged 32-bit frames -> FWFT FIFO -> AXI-Stream master.
// Optional build macro GVP_PACK_TIMESTAMP_EN inserts a request-time cycle counter after each tag.

// Generic first-word-fall-through FIFO, power-of-two depth.
// Latency: write visible on rd_* the cycle after wr_vld.
// Backpressure: writes while full are ignored; rd_dat/rd_vld hold while !rd_rdy.
module gvp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    assign rd_vld  = (level != '0);
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;
    assign wr_fire = wr_vld && (level != (AW+1)'(DEPTH));
    assign rd_fire = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Frame packer: snapshots gvp outputs on a store/finished request and streams them as a tagged frame.
// Latency: request at cycle N -> tag in FIFO at N+1, tvalid at N+2 when the FIFO was empty.
// Backpressure: frames are admitted only if they fit whole; otherwise dropped and counted in overrun_count.
module gvp_stream_packer #(
    parameter int FIFO_DEPTH = 64,
    parameter int SEQ_W      = 12
) (
    input  logic                          a_clk,
    input  logic                          a_resetn,
    input  logic                          enable,
    input  logic [31:0]                   x,
    input  logic [31:0]                   y,
    input  logic [31:0]                   z,
    input  logic [31:0]                   u,
    input  logic [31:0]                   options,
    input  logic [31:0]                   section,
    input  logic [1:0]                    store_data,
    input  logic                          gvp_finished,
    output logic [31:0]                   M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overrun_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef GVP_PACK_TIMESTAMP_EN
    localparam int TS_WORDS = 1;
`else
    localparam int TS_WORDS = 0;
`endif
    localparam int HDR_LEN = 7 + TS_WORDS;
    localparam int DAT_LEN = 5 + TS_WORDS;
    localparam int END_LEN = 1 + TS_WORDS;

    localparam logic [3:0] T_HDR = 4'hA;
    localparam logic [3:0] T_DAT = 4'hD;
    localparam logic [3:0] T_END = 4'hE;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [1:0]  prev_store;
    logic        prev_fin;
    logic        store_rise;
    logic        fin_rise;
    logic        store_hdr;

    logic [AW:0] level;
    logic [AW:0] free;
    logic        busy;

    logic        load;
    logic        load_pend;
    logic [3:0]  ld_type;
    logic [1:0]  drops;
    logic        pend_set;
    logic        pend_clr;

    logic        pend_end;
    logic [15:0] pend_sec;

    logic [3:0]  h_type;
    logic [SEQ_W-1:0] h_seq;
    logic [SEQ_W-1:0] seq;
    logic [2:0]  h_last;
    logic [31:0] h_sec;
    logic [31:0] h_opt;
    logic [31:0] h_x;
    logic [31:0] h_y;
    logic [31:0] h_z;
    logic [31:0] h_u;
    logic [2:0]  idx;

    logic [31:0] body [8];
    logic [2:0]  bidx;
    logic [31:0] word;
    logic        wr_vld;
    logic [32:0] wr_dat;
    logic [32:0] rd_dat;
    logic [16:0] ovr_sum;

`ifdef GVP_PACK_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] pend_ts;
    logic [31:0] h_ts;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) ts_cnt <= '0;
        else           ts_cnt <= ts_cnt + 32'd1;
    end
`endif

    assign store_rise = enable && (prev_store == 2'd0) && (store_data != 2'd0);
    assign fin_rise   = enable && gvp_finished && !prev_fin;
    assign store_hdr  = store_data[1];
    assign busy       = (state != IDLE);
    assign free       = (AW+1)'(FIFO_DEPTH) - level;

    // Admission: a pending end frame goes first, then the store request, then a lone finished rise.
    always_comb begin
        load      = 1'b0;
        load_pend = 1'b0;
        ld_type   = T_DAT;
        drops     = 2'd0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        if (pend_end && !busy) begin
            pend_clr = 1'b1;
            if (free >= (AW+1)'(END_LEN)) begin
                load      = 1'b1;
                load_pend = 1'b1;
                ld_type   = T_END;
            end else begin
                drops = drops + 2'd1;
            end
        end
        if (store_rise) begin
            if (!busy && !load &&
                free >= (store_hdr ? (AW+1)'(HDR_LEN) : (AW+1)'(DAT_LEN))) begin
                load    = 1'b1;
                ld_type = store_hdr ? T_HDR : T_DAT;
            end else begin
                drops = drops + 2'd1;
            end
            pend_set = fin_rise;
        end else if (fin_rise) begin
            if (!busy && !load && free >= (AW+1)'(END_LEN)) begin
                load    = 1'b1;
                ld_type = T_END;
            end else begin
                drops = drops + 2'd1;
            end
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = WRITE;
            WRITE:   if (idx == h_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        body = '{default: '0};
        if (h_type == T_HDR) begin
            body[0] = h_sec;
            body[1] = h_opt;
            body[2] = h_x;
            body[3] = h_y;
            body[4] = h_z;
            body[5] = h_u;
        end else begin
            body[0] = h_x;
            body[1] = h_y;
            body[2] = h_z;
            body[3] = h_u;
        end
        bidx = idx - 3'(1 + TS_WORDS);
        word = body[bidx];
        if (idx == 3'd0) word = {h_type, 12'(h_seq), h_sec[15:0]};
`ifdef GVP_PACK_TIMESTAMP_EN
        if (idx == 3'd1) word = h_ts;
`endif
    end

    always_comb begin
        wr_vld = (state == WRITE);
        wr_dat = {(idx == h_last), word};
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            prev_store <= '0;
            prev_fin   <= 1'b0;
            pend_end   <= 1'b0;
            pend_sec   <= '0;
            seq        <= '0;
            idx        <= '0;
            h_type     <= T_DAT;
            h_seq      <= '0;
            h_last     <= '0;
            h_sec      <= '0;
            h_opt      <= '0;
            h_x        <= '0;
            h_y        <= '0;
            h_z        <= '0;
            h_u        <= '0;
`ifdef GVP_PACK_TIMESTAMP_EN
            pend_ts    <= '0;
            h_ts       <= '0;
`endif
        end else begin
            prev_store <= store_data;
            prev_fin   <= gvp_finished;
            if (pend_set) begin
                pend_end <= 1'b1;
                pend_sec <= section[15:0];
`ifdef GVP_PACK_TIMESTAMP_EN
                pend_ts  <= ts_cnt;
`endif
            end else if (pend_clr) begin
                pend_end <= 1'b0;
            end
            if (state == WRITE) idx <= (idx == h_last) ? 3'd0 : idx + 3'd1;
            if (load) begin
                seq    <= seq + 1'b1;
                idx    <= '0;
                h_type <= ld_type;
                h_seq  <= seq;
                h_last <= (ld_type == T_HDR) ? 3'(HDR_LEN - 1) :
                          (ld_type == T_DAT) ? 3'(DAT_LEN - 1) : 3'(END_LEN - 1);
                if (load_pend) begin
                    h_sec <= {16'h0000, pend_sec};
`ifdef GVP_PACK_TIMESTAMP_EN
                    h_ts  <= pend_ts;
`endif
                end else begin
                    h_sec <= section;
                    h_opt <= options;
                    h_x   <= x;
                    h_y   <= y;
                    h_z   <= z;
                    h_u   <= u;
`ifdef GVP_PACK_TIMESTAMP_EN
                    h_ts  <= ts_cnt;
`endif
                end
            end
        end
    end

    // Two drops can land in one cycle (e.g. store and finished both refused).
    assign ovr_sum = {1'b0, overrun_count} + {15'd0, drops};

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn)      overrun_count <= '0;
        else if (ovr_sum[16]) overrun_count <= 16'hFFFF;
        else                overrun_count <= ovr_sum[15:0];
    end

    gvp_fifo #(.W(33), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (a_clk),
        .rst_n  (a_resetn),
        .wr_vld (wr_vld),
        .wr_dat (wr_dat),
        .rd_vld (M_AXIS_tvalid),
        .rd_rdy (M_AXIS_tready),
        .rd_dat (rd_dat),
        .level  (level)
    );

    assign M_AXIS_tdata = rd_dat[31:0];
    assign M_AXIS_tlast = rd_dat[32];
    assign fifo_level   = level;
endmodule

// File: tb/tb_gvp_stream_packer.sv
// Directed bench for gvp_stream_packer with a scoreboard of expected stream words.
module tb_gvp_stream_packer;
    localparam int DEPTH = 16;

    logic        a_clk = 1'b0;
    logic        a_resetn;
    logic        enable;
    logic [31:0] x, y, z, u, options, section;
    logic [1:0]  store_data;
    logic        gvp_finished;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic        M_AXIS_tlast;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0] overrun_count;

    logic [32:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tb_seq = 0;
    logic [31:0] last_tag = '0;
    logic        at_start = 1'b1;
    logic [32:0] got_w;
    logic [32:0] want_w;

    always #5 a_clk = ~a_clk;

    gvp_stream_packer #(.FIFO_DEPTH(DEPTH), .SEQ_W(12)) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .enable        (enable),
        .x             (x),
        .y             (y),
        .z             (z),
        .u             (u),
        .options       (options),
        .section       (section),
        .store_data    (store_data),
        .gvp_finished  (gvp_finished),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .fifo_level    (fifo_level),
        .overrun_count (overrun_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge a_clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [3:0] typ, input int sq, input logic [31:0] sec);
        logic [31:0] w [$];
        w.push_back({typ, 12'(sq), sec[15:0]});
        if (typ == 4'hA) begin
            w.push_back(sec);
            w.push_back(options);
        end
        if (typ != 4'hE) begin
            w.push_back(x);
            w.push_back(y);
            w.push_back(z);
            w.push_back(u);
        end
        foreach (w[i]) exp_q.push_back({(i == w.size() - 1), w[i]});
    endtask

    task automatic req_store(input logic [1:0] sd, input bit accept);
        store_data = sd;
        if (accept) begin
            push_frame(sd[1] ? 4'hA : 4'hD, tb_seq, section);
            tb_seq = (tb_seq + 1) % 4096;
        end
        tick(1);
        store_data = 2'd0;
        tick(7);
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Stream monitor: transfers are sampled on the falling edge, between stimulus updates.
    always @(negedge a_clk) begin
        if (!a_resetn) begin
            at_start = 1'b1;
        end else if (M_AXIS_tvalid && M_AXIS_tready) begin
            got_w = {M_AXIS_tlast, M_AXIS_tdata};
            if (at_start) last_tag = M_AXIS_tdata;
            at_start = M_AXIS_tlast;
            if (exp_q.size() == 0) begin
                check("stream_extra_word", 64'(got_w), 64'h1_FFFF_FFFF);
            end else begin
                want_w = exp_q.pop_front();
                check("stream_word", 64'(got_w), 64'(want_w));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout compared=%0d", n_cmp);
        $fatal(1, "bench time limit expired");
    end

    initial begin
        logic [31:0] hold_d;
        logic        hold_l;
        logic        hold_v;
        bit          stable;

        a_resetn = 1'b0; enable = 1'b1; store_data = 2'd0; gvp_finished = 1'b0;
        x = '0; y = '0; z = '0; u = '0; options = '0; section = '0;
        M_AXIS_tready = 1'b1;
        tick(2);
        check("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("rst_tdata",  64'(M_AXIS_tdata),  64'd0);
        check("rst_tlast",  64'(M_AXIS_tlast),  64'd0);
        check("rst_level",  64'(fifo_level),    64'd0);
        check("rst_overrun", 64'(overrun_count), 64'd0);
        a_resetn = 1'b1;
        tick(2);

        // Header then data with the reference values.
        section = 32'd3; options = 32'd1; x = 32'hFFFF_FFFE; y = 32'hFFFF_FFFE; z = '0; u = '0;
        req_store(2'd2, 1'b1);
        wait_drain("hdr_drain");
        store_data = 2'd1;
        push_frame(4'hD, tb_seq, section);
        tb_seq++;
        tick(1);
        store_data = 2'd0;
        check("lat_n1_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        tick(1);
        check("lat_n2_tvalid", 64'(M_AXIS_tvalid), 64'd1);
        tick(6);
        wait_drain("data_drain");

        // Backpressure across a whole data frame.
        section = 32'h0000_0107; x = 32'h1111_2222; y = 32'h3333_4444; z = 32'h5555_6666; u = 32'h7777_8888;
        M_AXIS_tready = 1'b0;
        req_store(2'd1, 1'b1);
        check("bp_level", 64'(fifo_level), 64'd5);
        hold_d = M_AXIS_tdata; hold_l = M_AXIS_tlast; hold_v = M_AXIS_tvalid;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (M_AXIS_tdata !== hold_d || M_AXIS_tlast !== hold_l || M_AXIS_tvalid !== hold_v)
                stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'd1);
        check("bp_tvalid", 64'(M_AXIS_tvalid), 64'd1);
        M_AXIS_tready = 1'b1;
        wait_drain("bp_drain");

        // Requests are ignored while disabled.
        enable = 1'b0;
        req_store(2'd1, 1'b0);
        check("dis_level", 64'(fifo_level), 64'd0);
        check("dis_overrun", 64'(overrun_count), 64'd0);
        enable = 1'b1;

        // Overflow: three frames fill 15 of 16 words, the fourth is refused.
        M_AXIS_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 32'(i + 100);
            req_store(2'd1, 1'b1);
        end
        x = 32'hBAD0_0000;
        req_store(2'd1, 1'b0);
        check("ovf_overrun", 64'(overrun_count), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd15);
        M_AXIS_tready = 1'b1;
        wait_drain("ovf_drain");
        tick(1);
        check("ovf_level_empty", 64'(fifo_level), 64'd0);

        // Reset during WRITE discards everything.
        section = 32'h0000_0042;
        store_data = 2'd2;
        push_frame(4'hA, tb_seq, section);
        tick(1);
        store_data = 2'd0;
        tick(2);
        a_resetn = 1'b0;
        exp_q.delete();
        tb_seq = 0;
        #1;
        check("mrst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        check("mrst_tdata",  64'(M_AXIS_tdata),  64'd0);
        check("mrst_tlast",  64'(M_AXIS_tlast),  64'd0);
        check("mrst_level",  64'(fifo_level),    64'd0);
        check("mrst_overrun", 64'(overrun_count), 64'd0);
        tick(2);
        a_resetn = 1'b1;
        tick(2);
        req_store(2'd1, 1'b1);
        wait_drain("mrst_next_drain");
        check("mrst_next_tag", 64'(last_tag), 64'hD000_0042);

        // Finished rising together with a data request.
        section = 32'h0000_0055;
        store_data = 2'd1;
        gvp_finished = 1'b1;
        push_frame(4'hD, tb_seq, section);
        push_frame(4'hE, tb_seq + 1, section);
        tb_seq += 2;
        tick(1);
        store_data = 2'd0;
        tick(12);
        gvp_finished = 1'b0;
        wait_drain("fin_drain");
        check("fin_end_tag", 64'(last_tag), 64'hE002_0055);
        check("fin_overrun", 64'(overrun_count), 64'd0);

        // Sequence wrap: 4097 data frames from a clean reset.
        a_resetn = 1'b0;
        exp_q.delete();
        tb_seq = 0;
        tick(2);
        a_resetn = 1'b1;
        tick(2);
        section = 32'h0000_0009;
        for (int i = 0; i < 4097; i++) begin
            x = 32'(i);
            y = ~32'(i);
            req_store(2'd1, 1'b1);
        end
        wait_drain("wrap_drain");
        check("wrap_tag", 64'(last_tag), 64'hD000_0009);
        check("wrap_overrun", 64'(overrun_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
